// File: rtl/sn_spike_sched.sv
// Spike transmit scheduler: snapshots pending neurons on a transmit-period rising edge and grants them one at a time to the axon bus.
// Optional round-robin start pointer enabled by defining SN_SPIKE_SCHED_RR_EN; default build always scans from index 1.
module sn_spike_sched #(
  parameter int P_NUM_NEURONS = 100,
  parameter int P_NUM_OUTPUTS = 3,
  localparam int N  = P_NUM_NEURONS - P_NUM_OUTPUTS,
  localparam int IW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nc_transmit,
  input  logic [N:1]    api_pending,
  input  logic          bus_rdy,
  output logic [N:1]    api_granted,
  output logic [IW-1:0] api_idx,
  output logic          api_vld,
  output logic          api_nc_done,
  output logic          sched_busy
);

  // state | meaning
  // IDLE  | waiting for a transmit-period rising edge
  // GRANT | presenting one grant per cycle from the snapshot mask
  // DONE  | one-cycle end-of-period pulse
  // HOLD  | period finished, waiting for nc_transmit to drop
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [N:1]    mask;
  logic [N:1]    mask_left;
  logic [N:1]    gnt;
  logic [IW-1:0] sel;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pi;
  logic [IW:0]   pos;
  logic          hit;
  logic          nc_q;

  // Scan the mask starting at ptr, wrapping N back to 1; first set bit wins.
  always_comb begin
    sel = '0;
    gnt = '0;
    hit = 1'b0;
    pos = '0;
    pi  = '0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (IW+1)'(off);
      if (pos > (IW+1)'(N)) pos = pos - (IW+1)'(N);
      pi = pos[IW-1:0];
      if (!hit && mask[pi]) begin
        hit     = 1'b1;
        sel     = pi;
        gnt[pi] = 1'b1;
      end
    end
  end

  assign mask_left = mask & ~gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mask  <= '0;
      nc_q  <= 1'b0;
    end else begin
      nc_q <= nc_transmit;
      case (state)
        S_IDLE: begin
          if (nc_transmit && !nc_q) begin
            mask  <= api_pending;
            state <= (|api_pending) ? S_GRANT : S_DONE;
          end
        end
        S_GRANT: begin
          // A falling transmit level aborts the period without the done pulse.
          if (!nc_transmit) begin
            mask  <= '0;
            state <= S_IDLE;
          end else if (bus_rdy) begin
            mask <= mask_left;
            if (mask_left == '0) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_HOLD;
        S_HOLD:  if (!nc_transmit) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SN_SPIKE_SCHED_RR_EN
  // Pointer moves past every accepted grant, including one accepted during an abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(1);
    end else if (state == S_GRANT && hit && bus_rdy) begin
      ptr <= (sel == IW'(N)) ? IW'(1) : sel + IW'(1);
    end
  end
`else
  assign ptr = IW'(1);
`endif

  assign api_vld     = (state == S_GRANT) && hit;
  assign api_granted = api_vld ? gnt : '0;
  assign api_idx     = api_vld ? sel : '0;
  assign api_nc_done = (state == S_DONE);
  assign sched_busy  = (state == S_GRANT) || (state == S_DONE);

endmodule

// File: tb/tb_sn_spike_sched.sv
// Randomized bench for sn_spike_sched (N=8): each period's grant order is predicted from the snapshot and start pointer.
module tb_sn_spike_sched;

  localparam int N  = 8;
  localparam int IW = 4;
`ifdef SN_SPIKE_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          nc_transmit;
  logic [N:1]    api_pending;
  logic          bus_rdy;
  logic [N:1]    api_granted;
  logic [IW-1:0] api_idx;
  logic          api_vld;
  logic          api_nc_done;
  logic          sched_busy;

  int n_checks = 0;
  int n_errs   = 0;
  int m_ptr    = 1;

  sn_spike_sched #(.P_NUM_NEURONS(10), .P_NUM_OUTPUTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .nc_transmit(nc_transmit), .api_pending(api_pending),
    .bus_rdy(bus_rdy), .api_granted(api_granted), .api_idx(api_idx), .api_vld(api_vld),
    .api_nc_done(api_nc_done), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N:1] onehot(input int j);
    return 8'd1 << (j - 1);
  endfunction

  task automatic chk_quiet(input string tag, input logic done_exp, input logic busy_exp);
    chk({tag, "_vld"},  32'(api_vld), 32'd0);
    chk({tag, "_gnt"},  32'(api_granted), 32'd0);
    chk({tag, "_idx"},  32'(api_idx), 32'd0);
    chk({tag, "_done"}, 32'(api_nc_done), 32'(done_exp));
    chk({tag, "_busy"}, 32'(sched_busy), 32'(busy_exp));
  endtask

  // One transmit period. abort_cyc / rst_cyc: grant-cycle number at which nc drops or reset hits (-1 = never).
  task automatic run_period(input logic [N:1] pend, input int stall_pct, input int first_stall,
                            input int abort_cyc, input int rst_cyc, input bit via_reset);
    int q[$];
    int cyc;
    int nh;
    bit rdy;
    @(negedge clk);
    api_pending = pend;
    nc_transmit = 1'b1;
    bus_rdy     = 1'b0;
    if (via_reset) begin
      rst_n = 1'b0;
      @(negedge clk);
      chk_quiet("rst_hold", 1'b0, 1'b0);
      m_ptr = 1;
      rst_n = 1'b1;
    end
    for (int off = 0; off < N; off++) begin
      int j;
      j = ((m_ptr - 1 + off) % N) + 1;
      if (((pend >> (j - 1)) & 8'd1) != 0) q.push_back(j);
    end
    @(negedge clk);
    cyc = 0;
    while (q.size() > 0) begin
      chk("grant_vld",  32'(api_vld), 32'd1);
      chk("grant_idx",  32'(api_idx), 32'(q[0]));
      chk("grant_gnt",  32'(api_granted), 32'(onehot(q[0])));
      chk("grant_busy", 32'(sched_busy), 32'd1);
      chk("grant_done", 32'(api_nc_done), 32'd0);
      rdy = (cyc < first_stall) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      bus_rdy     = rdy;
      api_pending = 8'($urandom);
      if (cyc == rst_cyc) begin
        rst_n       = 1'b0;
        bus_rdy     = 1'b1;
        nc_transmit = 1'b0;
        @(negedge clk);
        chk_quiet("rst_mid", 1'b0, 1'b0);
        m_ptr = 1;
        rst_n = 1'b1;
        return;
      end
      if (rdy && RR) m_ptr = (q[0] == N) ? 1 : q[0] + 1;
      if (cyc == abort_cyc) begin
        nc_transmit = 1'b0;
        @(negedge clk);
        chk_quiet("abort", 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("abort_after", 1'b0, 1'b0);
        return;
      end
      if (rdy) void'(q.pop_front());
      cyc++;
      if (cyc > 400) begin
        chk("grant_budget", 32'(cyc), 32'd400);
        break;
      end
      @(negedge clk);
    end
    chk_quiet("done_cycle", 1'b1, 1'b1);
    bus_rdy = 1'($urandom);
    nh = $urandom_range(1, 3);
    repeat (nh) begin
      api_pending = 8'($urandom) | 8'd1;
      @(negedge clk);
      chk_quiet("hold", 1'b0, 1'b0);
    end
    nc_transmit = 1'b0;
    @(negedge clk);
    chk_quiet("idle", 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    nc_transmit = 1'b0;
    api_pending = '0;
    bus_rdy     = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_period(8'b1010_0100, 0, 0, -1, -1, 1'b0);
    run_period(8'b0000_0000, 0, 0, -1, -1, 1'b0);
    run_period(8'b0000_0011, 0, 3, -1, -1, 1'b0);
    run_period(8'b0001_0110, 0, 0,  1, -1, 1'b0);
    run_period(8'b1100_1000, 0, 0, -1, -1, 1'b0);
    run_period(8'b1000_0001, 0, 0, -1, -1, 1'b1);
    run_period(8'b0000_0101, 0, 0, -1, -1, 1'b0);
    run_period(8'b0000_0100, 0, 0, -1, -1, 1'b0);
    run_period(8'b0010_0001, 0, 0, -1, -1, 1'b0);
    run_period(8'b1110_0000, 0, 0, -1,  1, 1'b0);
    run_period(8'b1111_1111, 0, 0, -1, -1, 1'b0);

    for (int p = 0; p < 40; p++) begin
      int ab;
      int rs;
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      run_period(8'($urandom), $urandom_range(0, 60), $urandom_range(0, 2), ab, rs,
                 ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/sn_spike_sched.md
SN_SPIKE_SCHED -- requirements
Module: sn_spike_sched

Interface
REQ-001 SHALL have parameter P_NUM_NEURONS, default 100: total neurons in network.
REQ-002 SHALL have parameter P_NUM_OUTPUTS, default 3: output-layer neurons, which never transmit. N = P_NUM_NEURONS-P_NUM_OUTPUTS; IW = $clog2(N+1).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port nc_transmit, input, 1 bit: network-controller transmit-period level.
REQ-006 SHALL have port api_pending, input, [N:1]: per-neuron spike pending.
REQ-007 SHALL have port bus_rdy, input, 1 bit: axon bus accepts the current grant.
REQ-008 SHALL have port api_granted, output, [N:1]: one-hot grant.
REQ-009 SHALL have port api_idx, output, IW bits: index of granted neuron, 0 when none.
REQ-010 SHALL have port api_vld, output, 1 bit: a grant is presented.
REQ-011 SHALL have port api_nc_done, output, 1 bit: one-cycle end-of-period pulse.
REQ-012 SHALL have port sched_busy, output, 1 bit: high in states SNAP-free GRANT or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, DONE, HOLD.
REQ-014 SHALL, in IDLE on nc_transmit rising edge (nc_transmit=1, registered prior value 0), load mask<=api_pending and go to GRANT if mask nonzero, else DONE.
REQ-015 SHALL, in GRANT, drive api_granted one-hot at the selected set mask bit, api_idx to its index, api_vld=1, all combinational from registered state/mask/pointer.
REQ-016 SHALL select the first set mask bit scanning ascending from index ptr, wrapping N->1.
REQ-017 SHALL, when bus_rdy=1 in GRANT, clear the granted mask bit; grant holds unchanged while bus_rdy=0.
REQ-018 SHALL go GRANT->DONE in the cycle the last mask bit is accepted; M pending neurons with bus_rdy=1 give grants in cycles k+1..k+M and api_nc_done in cycle k+M+1 (k = edge-sample cycle).
REQ-019 SHALL assert api_nc_done for exactly one cycle in DONE, then go to HOLD.
REQ-020 SHALL remain in HOLD until nc_transmit=0, then go to IDLE; no new period starts without a fresh rising edge.
REQ-021 SHALL ignore api_pending changes after the snapshot; a neuron dropping pending mid-period is still granted.
REQ-022 SHALL, if nc_transmit falls in GRANT, abort: clear mask, go to IDLE, suppress api_nc_done; the same-cycle grant is still presented and an acceptance is honoured.
REQ-023 SHALL drive api_granted=0, api_idx=0, api_vld=0 outside GRANT.
REQ-024 SHALL never assert more than one api_granted bit.

Reset
REQ-025 SHALL, with rst_n=0 at a clock edge, set state=IDLE, mask=0, ptr=1, prior nc_transmit=0, all outputs 0, including mid-period; reset dominates all inputs.
REQ-026 SHALL, after reset release with nc_transmit already high, treat it as a rising edge.

Configuration
REQ-027 SHALL honour macro SN_SPIKE_SCHED_RR_EN: defined -> ptr updates to (accepted index+1), wrapping N->1, on every acceptance and persists across periods (round-robin); undefined -> ptr fixed at 1 (lowest index first), no pointer register.

Verification
REQ-028 SHALL cover, with P_NUM_NEURONS=10, P_NUM_OUTPUTS=2 (N=8): pending=8'b1010_0100, bus_rdy=1, edge at cycle k -> api_idx 3,6,8 in cycles k+1..k+3, api_nc_done in k+4 only.
REQ-029 SHALL cover pending=0 at edge -> no api_vld; api_nc_done in cycle k+1; HOLD until nc_transmit low.
REQ-030 SHALL cover pending=8'b0000_0011 with bus_rdy low 3 cycles on first grant -> idx 1 held 4 cycles, then idx 2, then done.
REQ-031 SHALL cover nc_transmit dropping after first of three grants -> IDLE, no api_nc_done; next edge resnapshots fresh pending.
REQ-032 SHALL cover RR_EN: period 1 pending=8'b1000_0001 then period 2 pending=8'b0000_0101 -> period 2 order idx 1,3 (ptr wrapped to 1 after idx 8); with ptr=4 via single-grant idx 3, pending=8'b0010_0001 -> order 6,1; without macro -> 1,6.
REQ-033 SHALL cover rst_n=0 mid-GRANT -> next cycle all outputs 0, state IDLE, ptr=1.
